// File: rtl/fifo_rr_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_reader_if
// Purpose  : Bundles the FIFO pop-side signals and the downstream
//            valid/ready port of the round-robin FIFO reader.
// Ports    : in_empty  - per-FIFO empty flags (from FIFOs)
//            in_data   - per-FIFO pop_data words (from FIFOs)
//            in_pop    - per-FIFO pop strobes (to FIFOs)
//            out_valid - output word present (to downstream)
//            out_data  - output word (to downstream)
//            out_id    - source FIFO index of out_data (to downstream)
//            out_ready - downstream accepts (from downstream)
// Modports : master - the reader; slave - FIFOs plus downstream consumer
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_rr_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_IN     = 4
);
   localparam int ID_W = $clog2(NUM_IN);

   logic [NUM_IN-1:0]                 in_empty;
   logic [NUM_IN-1:0][DATA_WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]                 in_pop;
   logic                              out_valid;
   logic [DATA_WIDTH-1:0]             out_data;
   logic [ID_W-1:0]                   out_id;
   logic                              out_ready;

   modport master (
      input  in_empty, in_data, out_ready,
      output in_pop, out_valid, out_data, out_id
   );

   modport slave (
      output in_empty, in_data, out_ready,
      input  in_pop, out_valid, out_data, out_id
   );
endinterface
`default_nettype wire

// File: rtl/fifo_rr_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_reader
// Purpose  : Round-robin reader draining NUM_IN upstream FIFOs into a single
//            registered valid/ready output, one word per cycle.
// Ports    : clk - clock, rising edge
//            rst - synchronous active-high reset
//            bus - fifo_rr_reader_if.master (FIFO pop side + output port)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_IN     = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   fifo_rr_reader_if.master     bus
);
   localparam int ID_W = $clog2(NUM_IN);

   generate
      if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
         $error("fifo_rr_reader: NUM_IN must be in 2..16");
      end
   endgenerate

   logic                  held_valid;
   logic [DATA_WIDTH-1:0] held_data;
   logic [ID_W-1:0]       held_id;
   logic [ID_W-1:0]       last_grant;

   logic                  load_en;
   logic                  found;
   logic [ID_W-1:0]       winner;
   logic [ID_W:0]         idx_sum;
   logic [NUM_IN-1:0]     pop;

   // Output register is free when empty or being drained this cycle.
   assign load_en = !held_valid || bus.out_ready;

   // Scan last_grant+1 .. last_grant+NUM_IN modulo NUM_IN; the first
   // non-empty FIFO wins. One extra bit on the sum keeps the wrap exact for
   // non-power-of-two NUM_IN.
   always_comb begin
      winner  = last_grant;
      found   = 1'b0;
      idx_sum = '0;
      for (int k = 1; k <= NUM_IN; k++) begin
         idx_sum = {1'b0, last_grant} + (ID_W+1)'(k);
         if (idx_sum >= (ID_W+1)'(NUM_IN)) begin
            idx_sum = idx_sum - (ID_W+1)'(NUM_IN);
         end
         if (!found && !bus.in_empty[idx_sum[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx_sum[ID_W-1:0];
         end
      end
   end

   always_comb begin
      pop = '0;
      if (!rst && load_en && found) begin
         pop[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         held_valid <= 1'b0;
         held_data  <= '0;
         held_id    <= '0;
         last_grant <= ID_W'(NUM_IN - 1);
      end else if (load_en) begin
         if (found) begin
            held_valid <= 1'b1;
            held_data  <= bus.in_data[winner];
            held_id    <= winner;
            last_grant <= winner;
         end else begin
            // Nothing to load: drop valid, keep the stale word/id.
            held_valid <= 1'b0;
         end
      end
   end

   assign bus.in_pop    = pop;
   assign bus.out_valid = held_valid;
   assign bus.out_data  = held_data;
   assign bus.out_id    = held_id;

`ifndef SYNTHESIS
   a_no_pop_when_empty : assert property (@(posedge clk) disable iff (rst)
      (pop & bus.in_empty) == '0);

   a_pop_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(pop));

   a_hold_stable : assert property (@(posedge clk) disable iff (rst)
      (held_valid && !bus.out_ready) |=> ($stable(held_data) && $stable(held_id)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_reader
// Purpose  : Directed and random self-checking bench for fifo_rr_reader
//            (DATA_WIDTH=8, NUM_IN=4) with behavioural upstream FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_reader;
   localparam int DW = 8;
   localparam int NI = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fifo_rr_reader_if #(.DATA_WIDTH(DW), .NUM_IN(NI)) bus ();

   fifo_rr_reader #(.DATA_WIDTH(DW), .NUM_IN(NI)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream FIFO contents and per-FIFO scoreboard of expected output order.
   logic [DW-1:0] q  [NI][$];
   logic [DW-1:0] sb [NI][$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int k = 0; k < NI; k++) begin
         bus.in_empty[k] = (q[k].size() == 0);
         bus.in_data[k]  = (q[k].size() != 0) ? q[k][0] : '0;
      end
   endtask

   task automatic push(input int k, input logic [DW-1:0] v);
      q[k].push_back(v);
      sb[k].push_back(v);
      refresh();
   endtask

   // One clock: capture pops just before the edge, apply them to the FIFO
   // model just after it.
   task automatic tick();
      logic [NI-1:0] p;
      #1;
      p = bus.in_pop;
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         if (p[k]) begin
            check("pop_nonempty", 32'(q[k].size() != 0), 32'd1);
            if (q[k].size() != 0) void'(q[k].pop_front());
         end
      end
      refresh();
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] nv;
      logic [DW-1:0] ev;
      int            id;
      int            left;
      checks = 0;
      errors = 0;
      nv     = '0;
      rst    = 1'b1;
      bus.out_ready = 1'b0;
      refresh();

      // Reset state
      tick();
      tick();
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_id", 32'(bus.out_id), 32'd0);
      check("rst_pop", 32'(bus.in_pop), 32'd0);
      check("rst_last_grant", 32'(dut.last_grant), 32'd3);
      rst = 1'b0;
      tick();

      // Single word from FIFO 2
      push(2, 8'hA1);
      bus.out_ready = 1'b1;
      #1;
      check("single_pop", 32'(bus.in_pop), 32'h4);
      tick();
      check("single_valid", 32'(bus.out_valid), 32'd1);
      check("single_data", 32'(bus.out_data), 32'hA1);
      check("single_id", 32'(bus.out_id), 32'd2);
      check("single_pop_after", 32'(bus.in_pop), 32'd0);
      tick();
      check("single_drop", 32'(bus.out_valid), 32'd0);

      // Full rotation, 3 words per FIFO, no bubbles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < NI; k++)
         for (int j = 0; j < 3; j++) push(k, DW'(k * 16 + j));
      for (int i = 0; i < 12; i++) begin
         tick();
         check("rot_valid", 32'(bus.out_valid), 32'd1);
         check("rot_id", 32'(bus.out_id), 32'(i % 4));
         check("rot_data", 32'(bus.out_data), 32'((i % 4) * 16 + i / 4));
      end
      tick();
      check("rot_end_valid", 32'(bus.out_valid), 32'd0);

      // Stall with data 0x10 held, FIFOs 1 and 3 waiting
      bus.out_ready = 1'b0;
      push(0, 8'h10);
      tick();
      push(1, 8'h11);
      push(3, 8'h30);
      #1;
      for (int i = 0; i < 5; i++) begin
         check("stall_pop", 32'(bus.in_pop), 32'd0);
         check("stall_valid", 32'(bus.out_valid), 32'd1);
         check("stall_data", 32'(bus.out_data), 32'h10);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("unstall_pop", 32'(bus.in_pop), 32'h2);
      tick();
      check("unstall_data", 32'(bus.out_data), 32'h11);
      check("unstall_id", 32'(bus.out_id), 32'd1);
      check("unstall_pop2", 32'(bus.in_pop), 32'h8);
      tick();
      check("unstall_data2", 32'(bus.out_data), 32'h30);
      check("unstall_id2", 32'(bus.out_id), 32'd3);
      tick();
      check("unstall_end", 32'(bus.out_valid), 32'd0);

      // Wrap-around from last_grant=3
      push(1, 8'h55);
      #1;
      check("wrap_pop1", 32'(bus.in_pop), 32'h2);
      tick();
      check("wrap_id1", 32'(bus.out_id), 32'd1);
      check("wrap_data1", 32'(bus.out_data), 32'h55);
      push(0, 8'h66);
      push(1, 8'h77);
      #1;
      check("wrap_pop0", 32'(bus.in_pop), 32'h1);
      tick();
      check("wrap_id0", 32'(bus.out_id), 32'd0);
      check("wrap_data0", 32'(bus.out_data), 32'h66);
      check("wrap_pop1b", 32'(bus.in_pop), 32'h2);
      tick();
      check("wrap_id1b", 32'(bus.out_id), 32'd1);
      check("wrap_data1b", 32'(bus.out_data), 32'h77);
      tick();
      check("wrap_end", 32'(bus.out_valid), 32'd0);

      // Reset mid-stream
      bus.out_ready = 1'b0;
      push(2, 8'h22);
      tick();
      check("mid_valid", 32'(bus.out_valid), 32'd1);
      push(1, 8'h12);
      push(3, 8'h33);
      bus.out_ready = 1'b1;
      rst = 1'b1;
      #1;
      check("mid_rst_pop", 32'(bus.in_pop), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("mid_after_valid", 32'(bus.out_valid), 32'd0);
      check("mid_after_data", 32'(bus.out_data), 32'd0);
      check("mid_after_lg", 32'(dut.last_grant), 32'd3);
      check("mid_after_pop", 32'(bus.in_pop), 32'h2);
      tick();
      check("mid_first_id", 32'(bus.out_id), 32'd1);
      check("mid_first_data", 32'(bus.out_data), 32'h12);
      check("mid_next_pop", 32'(bus.in_pop), 32'h8);
      tick();
      check("mid_second_data", 32'(bus.out_data), 32'h33);
      tick();
      check("mid_end", 32'(bus.out_valid), 32'd0);

      // Random stress with per-FIFO scoreboard
      for (int k = 0; k < NI; k++) sb[k].delete();
      for (int c = 0; c < 10000; c++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < NI; k++) begin
            if ($urandom_range(0, 4) == 0 && q[k].size() < 8) begin
               push(k, nv);
               nv = nv + 1'b1;
            end
         end
         #1;
         if (bus.out_valid && bus.out_ready) begin
            id = int'(bus.out_id);
            if (sb[id].size() == 0) begin
               check("stress_underflow", 32'd0, 32'd1);
            end else begin
               ev = sb[id].pop_front();
               check("stress_data", 32'(bus.out_data), 32'(ev));
            end
         end
         tick();
      end

      // Drain
      bus.out_ready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         #1;
         if (bus.out_valid) begin
            id = int'(bus.out_id);
            if (sb[id].size() == 0) begin
               check("drain_underflow", 32'd0, 32'd1);
            end else begin
               ev = sb[id].pop_front();
               check("drain_data", 32'(bus.out_data), 32'(ev));
            end
         end
         tick();
      end
      left = 0;
      for (int k = 0; k < NI; k++) left += sb[k].size();
      check("drain_left", 32'(left), 32'd0);
      check("drain_valid", 32'(bus.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_rr_reader.md
# fifo_rr_reader

Round-robin reader that drains NUM_IN upstream router FIFOs and forwards one word per cycle to a single downstream valid/ready port. It is the consumer side of the FIFO push/pop interface: it watches each FIFO's `empty` and `pop_data`, drives each FIFO's `pop`, and registers the selected word with its source index. It sits between the per-port input FIFOs and the router's output/switch stage.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each FIFO word.
- NUM_IN, 4, number of upstream FIFOs; legal range 2..16.
- ID_W, $clog2(NUM_IN), width of the source index (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_empty  in  NUM_IN  per-FIFO `empty` flag.
- in_data  in  NUM_IN x DATA_WIDTH  per-FIFO `pop_data`; valid whenever the matching in_empty is 0.
- in_pop  out  NUM_IN  per-FIFO `pop`; combinational, at most one bit set.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_WIDTH  registered word.
- out_id  out  ID_W  index of the FIFO the word came from.
- out_ready  in  1  downstream accepts; a transfer occurs on a cycle with out_valid && out_ready.

## Operation
- State: output register (out_valid, out_data, out_id) and the round-robin pointer last_grant (ID_W bits).
- The block can load a new word when `load_en = !out_valid || out_ready`.
- Arbitration is combinational. Scan indices last_grant+1, last_grant+2, … modulo NUM_IN, wrapping from NUM_IN-1 to 0. The first index with in_empty=0 is the winner.
- If load_en is 1 and a winner exists:
  - in_pop[winner] = 1.
  - On the next edge: out_data <= in_data[winner], out_id <= winner, out_valid <= 1, last_grant <= winner.
- If load_en is 1 and no FIFO is non-empty:
  - in_pop = 0.
  - On the next edge: out_valid <= 0. out_data and out_id hold their old values.
- If load_en is 0 (stall):
  - in_pop = 0.
  - out_valid, out_data, out_id and last_grant hold.
- in_pop never asserts for a FIFO whose in_empty is 1, never asserts during rst, and never has more than one bit set.
- Fairness: with all FIFOs continuously non-empty and no stalls, grants rotate 0,1,…,NUM_IN-1,0,…
- A FIFO that becomes non-empty waits at most NUM_IN-1 grants to other FIFOs.
- SIM_ONLY assertions, disabled during rst:
  - pop when empty;
  - in_pop not one-hot-or-zero;
  - out_data/out_id change while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_id=0, last_grant=NUM_IN-1 (so index 0 has first priority), in_pop=0.
- Latency: a word popped in cycle N is presented with out_valid=1 from cycle N+1.
- Throughput: one word per cycle. If out_valid && out_ready and a winner exists in the same cycle, the held word transfers, the next word is popped, and out_valid stays 1 with no bubble.
- Once out_valid=1, out_data and out_id stay stable until the cycle of transfer.
- in_empty and in_data are sampled combinationally in the pop cycle. A FIFO that goes non-empty in cycle N can first be popped in cycle N+1, because the FIFO flag is registered upstream.
- Reset mid-operation:
  - the held word is discarded and out_valid=0 on the cycle after rst is sampled high;
  - no pop occurs in any cycle where rst=1;
  - FIFO contents are not touched by this block.
- Simultaneous events: a transfer while no FIFO is non-empty drops out_valid on the next edge.

## Test plan
- Reset, then push 0xA1 into FIFO 2 only, out_ready=1 -> in_pop=4'b0100 for one cycle; next cycle out_valid=1, out_data=0xA1, out_id=2; the cycle after that out_valid=0.
- All 4 FIFOs preloaded with 3 words each (FIFO k holds 0xk0, 0xk1, 0xk2), out_ready=1 -> 12 consecutive valid cycles with out_id sequence 0,1,2,3,0,1,2,3,0,1,2,3, the matching data in FIFO order, and no bubble.
- Stall: out_valid=1 with data 0x10, out_ready=0 for 5 cycles while FIFOs 1 and 3 are non-empty -> in_pop=0 and out_data stays 0x10 throughout. Raise out_ready -> transfer occurs and FIFO 1 is popped in that same cycle (FIFO 1 is next after last_grant=0).
- Wrap-around: last_grant=3, only FIFO 1 non-empty -> FIFO 1 is granted. Then FIFO 0 and FIFO 1 are both non-empty -> FIFO 0 is granted before FIFO 1 again.
- Reset mid-stream: assert rst for 1 cycle while out_valid=1 and 2 FIFOs are non-empty -> in_pop=0 during the rst cycle; out_valid=0 and last_grant=3 after the reset edge; first grant afterwards goes to the lowest non-empty index.
- Random push/pop stress with random out_ready, 10k cycles -> scoreboard matches per-FIFO order, no pop-when-empty, no assertion fires.
